seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 25 ++
 rtl/shift_add_mul.sv | 45 ++++
 rtl/seq_alu.sv | 183 ++++++++++++++++++
 tb/tb_seq_alu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU:
// opcode and FSM state encodings.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_MUL = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_WB_LO = 2'd2,
    S_WB_HI = 2'd3
  } alu_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned multiplier, one
// multiplier bit retired per step.
module shift_add_mul #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [CW-1:0]   count,
  output logic            last,
  output logic [2*W-1:0]  product
);

  logic [W-1:0] mcand;
  logic [W:0]   sum;

  // add multiplicand into upper half when lsb set
  always_comb begin
    sum = {1'b0, product[2*W-1:W]}
        + (product[0] ? {1'b0, mcand} : '0);
  end

  assign last = (count == CW'(W - 1));

  // load operands, then shift right each step
  always_ff @(posedge clk) begin
    if (reset) begin
      product <= '0;
      mcand   <= '0;
      count   <= '0;
    end else if (load) begin
      product <= {{W{1'b0}}, b};
      mcand   <= a;
      count   <= '0;
    end else if (step) begin
      product <= {sum, product[W-1:1]};
      count   <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops write
// back next cycle, MUL runs W steps.
module seq_alu
  import alu_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] reg_in,
  input  logic [D-1:0] reg_sel,
  output logic         busy,
  output logic         done,
  output logic         write_enabled,
  output logic [D-1:0] reg_write_number,
  output logic [W-1:0] reg_write_data,
  output logic         carry_out,
  output logic         zero_out
);

  localparam int CW = $clog2(W);

  alu_state_t       state_q;
  alu_op_t          op_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [D-1:0]     sel_q;

  logic             mul_load;
  logic             mul_step;
  logic             mul_last;
  logic [CW-1:0]    mul_count;
  logic [2*W-1:0]   product;

  logic [W:0]       sum;
  logic [W-1:0]     res;
  logic             res_c;
  logic             op_ok;

  logic             flag_upd;
  logic             c_nxt;
  logic             z_nxt;

  assign busy     = (state_q != S_IDLE);
  assign mul_load = (state_q == S_IDLE) && start
                  && (alu_op_t'(op) == OP_MUL);
  assign mul_step = (state_q == S_MUL);

  shift_add_mul #(.W(W), .CW(CW)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .step    (mul_step),
    .a       (acc_in),
    .b       (reg_in),
    .count   (mul_count),
    .last    (mul_last),
    .product (product)
  );

  // single-cycle result from latched operands
  always_comb begin
    sum   = '0;
    res   = '0;
    res_c = carry_out;
    op_ok = 1'b1;
    case (op_q)
      OP_ADD: begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        res   = sum[W-1:0];
        res_c = sum[W];
      end
      OP_ADC: begin
        sum   = {1'b0, a_q} + {1'b0, b_q}
              + {{W{1'b0}}, carry_out};
        res   = sum[W-1:0];
        res_c = sum[W];
      end
      OP_SUB: begin
        res   = a_q - b_q;
        res_c = (a_q >= b_q);
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOT: res = ~a_q;
      OP_SHL: begin
        res   = {a_q[W-2:0], 1'b0};
        res_c = a_q[W-1];
      end
      OP_SHR: begin
        res   = {1'b0, a_q[W-1:1]};
        res_c = a_q[0];
      end
      default: op_ok = 1'b0;
    endcase
  end

  // write port, done pulse and flag next-values
  always_comb begin
    write_enabled    = 1'b0;
    reg_write_number = '0;
    reg_write_data   = '0;
    done             = 1'b0;
    flag_upd         = 1'b0;
    c_nxt            = carry_out;
    z_nxt            = zero_out;
    case (state_q)
      S_WB_LO: begin
        if (op_q == OP_MUL) begin
          write_enabled  = 1'b1;
          reg_write_data = product[W-1:0];
        end else if (op_ok) begin
          write_enabled  = 1'b1;
          reg_write_data = res;
          done           = 1'b1;
          flag_upd       = 1'b1;
          c_nxt          = res_c;
          z_nxt          = (res == '0);
        end
      end
      S_WB_HI: begin
        write_enabled    = 1'b1;
        reg_write_number = sel_q;
        reg_write_data   = product[2*W-1:W];
        done             = 1'b1;
        flag_upd         = 1'b1;
        c_nxt            = |product[2*W-1:W];
        z_nxt            = (product == '0);
      end
      default: ;
    endcase
  end

  // control FSM and operand capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= alu_op_t'(op);
            a_q     <= acc_in;
            b_q     <= reg_in;
            sel_q   <= reg_sel;
            state_q <= (alu_op_t'(op) == OP_MUL)
                     ? S_MUL : S_WB_LO;
          end
        end
        S_MUL: begin
          if (mul_last) state_q <= S_WB_LO;
        end
        S_WB_LO: begin
          state_q <= (op_q == OP_MUL)
                   ? S_WB_HI : S_IDLE;
        end
        S_WB_HI: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // flags change only at the end of a final write
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_out <= 1'b0;
      zero_out  <= 1'b0;
    end else if (flag_upd) begin
      carry_out <= c_nxt;
      zero_out  <= z_nxt;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu with a
// write-port scoreboard.
module tb_seq_alu;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] op;
  logic [7:0] acc_in;
  logic [7:0] reg_in;
  logic [3:0] reg_sel;
  logic       busy;
  logic       done;
  logic       write_enabled;
  logic [3:0] reg_write_number;
  logic [7:0] reg_write_data;
  logic       carry_out;
  logic       zero_out;

  typedef struct packed {
    logic [3:0] num;
    logic [7:0] data;
    logic       done;
  } wr_t;

  wr_t q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_wr  = 0;

  seq_alu #(.W(8), .D(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .op               (op),
    .acc_in           (acc_in),
    .reg_in           (reg_in),
    .reg_sel          (reg_sel),
    .busy             (busy),
    .done             (done),
    .write_enabled    (write_enabled),
    .reg_write_number (reg_write_number),
    .reg_write_data   (reg_write_data),
    .carry_out        (carry_out),
    .zero_out         (zero_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, got, exp);
    end
  endtask

  // advance one cycle, then check the write port
  task automatic tick();
    wr_t e;
    wr_t g;
    @(posedge clk);
    #1;
    if (write_enabled === 1'b1) begin
      n_wr++;
      n_cmp++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL spurious_write observed=%h expected=none",
               {reg_write_number, reg_write_data});
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        g = '{reg_write_number, reg_write_data, done};
        chk("write", 16'(g), 16'(e));
      end
    end else begin
      chk("idle_port",
          {3'b0, done, reg_write_number, reg_write_data},
          16'h0);
    end
  endtask

  task automatic issue(input logic [3:0] o,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [3:0] s);
    op = o; acc_in = a; reg_in = b; reg_sel = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic flags(input string tag,
                       input logic c,
                       input logic z);
    chk(tag, {14'b0, carry_out, zero_out},
        {14'b0, c, z});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0;
    acc_in = 8'h0; reg_in = 8'h0; reg_sel = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_we", 16'(write_enabled), 16'h0);
    flags("rst_flags", 1'b0, 1'b0);

    // ADD 7F+01
    q.push_back('{4'd0, 8'h80, 1'b1});
    issue(OP_ADD, 8'h7F, 8'h01, 4'd5);
    chk("add_busy", 16'(busy), 16'h1);
    tick();
    flags("add_flags", 1'b0, 1'b0);
    chk("add_idle", 16'(busy), 16'h0);

    // SUB equal, then ADC using carry
    q.push_back('{4'd0, 8'h00, 1'b1});
    issue(OP_SUB, 8'h05, 8'h05, 4'd0);
    tick();
    flags("sub_flags", 1'b1, 1'b1);
    q.push_back('{4'd0, 8'h00, 1'b1});
    issue(OP_ADC, 8'hFF, 8'h00, 4'd0);
    tick();
    flags("adc_flags", 1'b1, 1'b1);

    // AND keeps carry
    q.push_back('{4'd0, 8'h00, 1'b1});
    issue(OP_AND, 8'hF0, 8'h0F, 4'd0);
    tick();
    flags("and_flags", 1'b1, 1'b1);

    // MUL FF*FF to reg 3, stray start in cycle 3
    n_wr = 0;
    q.push_back('{4'd0, 8'h01, 1'b0});
    q.push_back('{4'd3, 8'hFE, 1'b1});
    issue(OP_MUL, 8'hFF, 8'hFF, 4'd3);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul_busy%0d", i),
          16'(busy), 16'h1);
      if (i == 3) begin
        op = OP_ADD; acc_in = 8'h11;
        reg_in = 8'h22; reg_sel = 4'd7;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    tick();
    tick();
    flags("mul_flags", 1'b1, 1'b0);
    chk("mul_idle", 16'(busy), 16'h0);
    chk("mul_nwr", 16'(n_wr), 16'd2);

    // reset in MUL cycle 4
    issue(OP_MUL, 8'h03, 8'h05, 4'd2);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 16'(busy), 16'h0);
    flags("abort_flags", 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) tick();

    // shifts
    q.push_back('{4'd0, 8'h02, 1'b1});
    issue(OP_SHL, 8'h81, 8'h00, 4'd0);
    tick();
    flags("shl_flags", 1'b1, 1'b0);
    q.push_back('{4'd0, 8'h00, 1'b1});
    issue(OP_SHR, 8'h01, 8'h00, 4'd0);
    tick();
    flags("shr_flags", 1'b1, 1'b1);

    // undefined opcode: one busy cycle, no write
    issue(4'hC, 8'h12, 8'h34, 4'd1);
    chk("undef_busy", 16'(busy), 16'h1);
    tick();
    chk("undef_idle", 16'(busy), 16'h0);
    flags("undef_flags", 1'b1, 1'b1);

    // MUL to reg 0: low byte zero, product not
    q.push_back('{4'd0, 8'h00, 1'b0});
    q.push_back('{4'd0, 8'h01, 1'b1});
    issue(OP_MUL, 8'h10, 8'h10, 4'd0);
    for (int i = 0; i < 10; i++) tick();
    flags("mul0_flags", 1'b1, 1'b0);

    // reset wins over start
    reset = 1'b1;
    op = OP_ADD; acc_in = 8'h01; reg_in = 8'h01;
    start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy", 16'(busy), 16'h0);
    tick();
    tick();

    chk("sb_empty", 16'(q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
